// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the 2-read/1-write register file:
//   - clr_state_t : state encoding of the sequential clear engine
//   - DEF_DATA_W / DEF_DEPTH : default geometry
//   - addr_w_of() : address width for a given depth (clog2, never below 1)
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // A two-entry file still needs one address bit, so clamp at 1.
  function automatic int addr_w_of(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// -----------------------------------------------------------------------------
// regfile_clear_seq
// Sequential clear engine: walks every entry once, writing zero, one entry per
// enabled cycle.
// Ports:
//   clk         clock (rising edge)
//   i_reset     synchronous active-high reset, returns engine to IDLE
//   i_enable    global enable; low freezes state and index
//   i_clr_req   start request, sampled while IDLE
//   o_busy      registered, high while the walk is in progress
//   o_clr_we    array write strobe for the current index
//   o_clr_addr  entry being cleared
// -----------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w_of(DEPTH)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;

  // Clear FSM, index counter and busy flag.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= CLR_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        CLR_IDLE: begin
          if (i_clr_req) begin
            r_state <= CLR_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= CLR_IDLE;
            r_idx   <= r_idx;
            r_busy  <= 1'b0;
          end
        end
        CLR_CLEAR: begin
          // The last entry is cleared on this same edge, so busy drops here
          // and stays high for exactly DEPTH enabled cycles.
          if (r_idx == LP_LAST_IDX) begin
            r_state <= CLR_DONE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= CLR_CLEAR;
            r_idx   <= r_idx + ADDR_W'(1);
            r_busy  <= 1'b1;
          end
        end
        CLR_DONE: begin
          r_state <= CLR_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= CLR_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end else begin
      r_state <= r_state;
      r_idx   <= r_idx;
      r_busy  <= r_busy;
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = (r_state == CLR_CLEAR);
  assign o_clr_addr = r_idx;

endmodule

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Parametrised register file, one write port and two independent registered
// read ports, with optional write-to-read bypass and a sequential clear engine.
// Ports:
//   clk, reset, enable                 clock, sync active-high reset, global enable
//   wr_en, wr_addr, wr_data            write request
//   wr_ack, wr_err                     one-cycle commit / reject strobes
//   rd_en_x, rd_addr_x                 read request, port A / B
//   rd_data_x, rd_valid_x              registered read data and valid strobe
//   clr_req, busy                      clear start request and clear-active flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w_of(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              clr_req,
  output logic              busy
);

  // One extra bit so DEPTH itself (e.g. 256 with 8 address bits) is representable.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] w_mem [DEPTH];
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd_next_a;
  logic [DATA_W-1:0] w_rd_next_b;

  logic              r_wr_ack;
  logic              r_wr_err;
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_rd_valid_a;
  logic              r_rd_valid_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < LP_DEPTH);
  endfunction

  // Value a read port captures this cycle, including same-cycle forwarding.
  function automatic logic [DATA_W-1:0] rd_next(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] mem_word,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    if (!in_range(addr)) begin
      v = '0;
    end else if ((BYPASS != 0) && we && (waddr == addr)) begin
      v = wdata;
    end else begin
      v = mem_word;
    end
    return v;
  endfunction

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .i_reset    (reset),
    .i_enable   (enable),
    .i_clr_req  (clr_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_wr_ok = wr_en && in_range(wr_addr) && !w_busy;

  // Array write port: clear engine has priority over the user write.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    if (w_clr_we) begin
      w_we    = 1'b1;
      w_waddr = w_clr_addr;
      w_wdata = '0;
    end else if (w_wr_ok) begin
      w_we    = 1'b1;
      w_waddr = wr_addr;
      w_wdata = wr_data;
    end else begin
      w_we    = 1'b0;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [DATA_W-1:0] r_word;

    // Storage for one entry; reset zeroes the whole array in one cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (enable && w_we && (w_waddr == ADDR_W'(g))) begin
        r_word <= w_wdata;
      end else begin
        r_word <= r_word;
      end
    end

    assign w_mem[g] = r_word;
  end

  assign w_rd_next_a = rd_next(rd_addr_a, w_mem[rd_addr_a], w_we, w_waddr, w_wdata);
  assign w_rd_next_b = rd_next(rd_addr_b, w_mem[rd_addr_b], w_we, w_waddr, w_wdata);

  // Write strobes and both read ports; strobes drop while disabled, data holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ack     <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_data_a  <= '0;
      r_rd_data_b  <= '0;
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
    end else if (enable) begin
      r_wr_ack <= w_wr_ok;
      r_wr_err <= wr_en && !w_wr_ok;
      if (rd_en_a) begin
        r_rd_data_a  <= w_rd_next_a;
        r_rd_valid_a <= 1'b1;
      end else begin
        r_rd_data_a  <= r_rd_data_a;
        r_rd_valid_a <= 1'b0;
      end
      if (rd_en_b) begin
        r_rd_data_b  <= w_rd_next_b;
        r_rd_valid_b <= 1'b1;
      end else begin
        r_rd_data_b  <= r_rd_data_b;
        r_rd_valid_b <= 1'b0;
      end
    end else begin
      r_wr_ack     <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_data_a  <= r_rd_data_a;
      r_rd_data_b  <= r_rd_data_b;
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
    end
  end

  assign wr_ack     = r_wr_ack;
  assign wr_err     = r_wr_err;
  assign rd_data_a  = r_rd_data_a;
  assign rd_data_b  = r_rd_data_b;
  assign rd_valid_a = r_rd_valid_a;
  assign rd_valid_b = r_rd_valid_b;
  assign busy       = w_busy;

endmodule
